// File: rtl/clk_divider_prog.sv
// clk_divider_prog: runtime-programmable integer clock divider.
//
// Produces a 50%-duty clock at clk_in / N for any N in 2..2^DIV_W-1. For odd
// N, a negedge register holds the output high for an extra half cycle.
// Ratio changes and stop requests both take effect only at a period
// boundary, so the output never produces a runt pulse.
//
// Ports:
//   clk_in       - sole clock (posedge logic; negedge for odd-N duty fix)
//   rst_n        - asynchronous active-low reset
//   enable       - run while high, graceful stop (finish period) when low
//   div_val      - requested ratio N
//   div_load     - one-cycle strobe capturing div_val
//   clk_out      - divided clock
//   clk_rise     - one-cycle pulse in the cycle clk_out rises
//   div_cur      - ratio currently in effect
//   load_pending - a captured ratio is waiting for a period boundary
//   load_err     - one-cycle pulse after a rejected load (div_val < 2)
//   running      - high in RUN or DRAIN
module clk_divider_prog #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             clk_rise,
    output logic [DIV_W-1:0] div_cur,
    output logic             load_pending,
    output logic             load_err,
    output logic             running
);

    if (DIV_W < 2 || DEFAULT_DIV < 2 || DEFAULT_DIV > (1 << DIV_W) - 1) begin : g_param_check
        $error("clk_divider_prog: DEFAULT_DIV must lie in 2..2^DIV_W-1 and DIV_W >= 2");
    end

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] pend;
    logic             pend_vld;
    logic             p_reg;
    logic             n_reg;
    logic             active;
    logic             boundary;
    logic             p_nxt;
    logic             load_ok;

    assign active   = (state != IDLE);
    assign boundary = active && (cnt == div_cur - ONE);
    // High for cnt in [0, floor(N/2)-1]; registered, so clk_out lags cnt by one cycle.
    assign p_nxt    = active && (cnt < (div_cur >> 1));
    assign load_ok  = div_load && (div_val >= MIN_DIV);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN: begin
                // Re-enable before the boundary resumes seamlessly; cnt is untouched.
                if (enable)        state_nxt = RUN;
                else if (boundary) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            p_reg    <= 1'b0;
            clk_rise <= 1'b0;
            load_err <= 1'b0;
        end else begin
            cnt      <= (!active || boundary) ? '0 : cnt + ONE;
            p_reg    <= p_nxt;
            clk_rise <= p_nxt && !p_reg;
            load_err <= div_load && (div_val < MIN_DIV);
        end
    end

    // Ratio update. While running, a new ratio only lands on a boundary; a load
    // in the boundary cycle itself is assigned after the boundary update, so it
    // survives as the next pending value.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_cur  <= DEF_DIV;
            pend     <= '0;
            pend_vld <= 1'b0;
        end else if (!active) begin
            if (load_ok) begin
                div_cur  <= div_val;
                pend_vld <= 1'b0;
            end else if (pend_vld) begin
                // Left over from a load that coincided with the final DRAIN boundary.
                div_cur  <= pend;
                pend_vld <= 1'b0;
            end
        end else begin
            if (boundary && pend_vld) begin
                div_cur  <= pend;
                pend_vld <= 1'b0;
            end
            if (load_ok) begin
                pend     <= div_val;
                pend_vld <= 1'b1;
            end
        end
    end

    // Half-cycle extension for odd N. Gated by the current ratio's LSB so even
    // ratios see n_reg = 0; the gate only matters while p_reg is high, which is
    // never at a ratio switch, so switching parity cannot glitch.
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) n_reg <= 1'b0;
        else        n_reg <= p_reg && div_cur[0];
    end

    assign clk_out      = p_reg | n_reg;
    assign running      = active;
    assign load_pending = pend_vld;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog. The reference model describes the
// output as a waveform in half-cycle units: within a period of ratio N the
// output is high for exactly the first N half-cycles and low for the next N.
// Directed phases follow the test plan; a randomized phase follows.
module tb_clk_divider_prog;

    localparam int W = 8;

    logic         clk_in = 1'b0;
    logic         rst_n  = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] div_val = '0;
    logic         div_load = 1'b0;
    logic         clk_out, clk_rise, load_pending, load_err, running;
    logic [W-1:0] div_cur;

    clk_divider_prog #(.DIV_W(W), .DEFAULT_DIV(16)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .enable      (enable),
        .div_val     (div_val),
        .div_load    (div_load),
        .clk_out     (clk_out),
        .clk_rise    (clk_rise),
        .div_cur     (div_cur),
        .load_pending(load_pending),
        .load_err    (load_err),
        .running     (running)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;

    // Model: m_st 0=stopped, 1=running, 2=stopping; m_pos = cycles into the
    // current period on the control side (output shows it one cycle later).
    int m_st, m_pos, m_n, m_pend, m_pv, m_err;
    bit prev_hi2, m_hi2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pos = 0; m_n = 16; m_pend = 0; m_pv = 0; m_err = 0;
        prev_hi2 = 1'b0; m_hi2 = 1'b0;
    endtask

    // One clk_in cycle: drive inputs, let the posedge sample them, then check
    // both half-cycles of the output against the model.
    task automatic step(input bit en, input bit ld, input int dv);
        bit hi1, rise, bnd;
        int nn, npv, npend;
        enable = en; div_load = ld; div_val = W'(dv);
        @(posedge clk_in);
        hi1   = (m_st != 0) && (2 * m_pos < m_n);
        m_hi2 = (m_st != 0) && (2 * m_pos + 1 < m_n);
        rise  = hi1 && !prev_hi2;
        bnd   = (m_st != 0) && (m_pos == m_n - 1);
        nn = m_n; npv = m_pv; npend = m_pend;
        if (m_st == 0) begin
            if (m_pv != 0) begin nn = m_pend; npv = 0; end
        end else if (bnd && m_pv != 0) begin
            nn = m_pend; npv = 0;
        end
        if (ld && dv >= 2) begin
            if (m_st == 0) begin nn = dv; npv = 0; end
            else begin npend = dv; npv = 1; end
        end
        m_err = (ld && dv < 2) ? 1 : 0;
        m_pos = (m_st == 0 || bnd) ? 0 : m_pos + 1;
        case (m_st)
            0:       m_st = en ? 1 : 0;
            1:       m_st = en ? 1 : 2;
            default: m_st = en ? 1 : (bnd ? 0 : 2);
        endcase
        m_n = nn; m_pv = npv; m_pend = npend;
        #1;
        chk("clk_out_first_half", clk_out, hi1);
        chk("clk_rise", clk_rise, rise);
        chk("div_cur", div_cur, m_n);
        chk("load_pending", load_pending, m_pv);
        chk("load_err", load_err, m_err);
        chk("running", running, m_st != 0);
        @(negedge clk_in);
        #1;
        chk("clk_out_second_half", clk_out, m_hi2);
        prev_hi2 = m_hi2;
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) step(en, 1'b0, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_clk_out"}, clk_out, 0);
        chk({tag, "_clk_rise"}, clk_rise, 0);
        chk({tag, "_div_cur"}, div_cur, 16);
        chk({tag, "_load_pending"}, load_pending, 0);
        chk({tag, "_load_err"}, load_err, 0);
        chk({tag, "_running"}, running, 0);
    endtask

    initial begin
        bit en_r;
        bit ld_r;
        int dv_r;
        model_reset();
        #12 rst_n = 1'b1;
        check_reset_vals("reset");

        // 1: default ratio 16 from reset
        run(50, 1'b1);

        // 2: loads in idle, odd and minimum ratios
        run(20, 1'b0);
        step(1'b0, 1'b1, 5);
        run(2, 1'b0);
        run(16, 1'b1);
        run(8, 1'b0);
        step(1'b0, 1'b1, 3);
        run(12, 1'b1);
        run(5, 1'b0);
        step(1'b0, 1'b1, 2);
        run(10, 1'b1);

        // 3: running at 16, load 6 part-way through a period
        step(1'b1, 1'b1, 16);
        for (int i = 0; i < 40 && !(m_st == 1 && m_pos == 3 && m_n == 16); i++) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 6);
        run(30, 1'b1);

        // 4: invalid loads, then back-to-back valid loads
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 4);
        step(1'b1, 1'b1, 7);
        run(25, 1'b1);

        // 5: graceful stop at 8, then a drain interrupted by re-enable
        step(1'b1, 1'b1, 8);
        for (int i = 0; i < 40 && !(m_st == 1 && m_pos == 2 && m_n == 8); i++) step(1'b1, 1'b0, 0);
        run(20, 1'b0);
        run(12, 1'b1);
        for (int i = 0; i < 20 && !(m_pos == 1); i++) step(1'b1, 1'b0, 0);
        for (int i = 0; i < 20 && !(m_pos == 5); i++) step(1'b0, 1'b0, 0);
        run(24, 1'b1);

        // 6: asynchronous reset in the middle of a high phase, with a pending load
        step(1'b1, 1'b1, 16);
        run(20, 1'b1);
        step(1'b1, 1'b1, 6);
        for (int i = 0; i < 40 && !(prev_hi2 && m_pv != 0); i++) step(1'b1, 1'b0, 0);
        chk("pre_reset_clk_out", clk_out, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_vals("async_reset");
        @(posedge clk_in);
        #2 rst_n = 1'b1;
        #1;
        check_reset_vals("after_release");
        run(40, 1'b1);

        // Randomized traffic: enable toggles occasionally, sporadic loads
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 3) en_r = !en_r;
            ld_r = ($urandom_range(99) < 6);
            dv_r = ($urandom_range(9) == 0) ? int'($urandom_range(1)) : int'($urandom_range(12, 2));
            step(en_r, ld_r, dv_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
